// File: rtl/life_engine.sv
// Double-buffered cellular-automaton engine: scans one cell per clock from the
// current plane into the next plane, then swaps planes at commit.
module life_engine #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 120,
    parameter bit         WRAP         = 1'b1,
    parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
    parameter int         GEN_W        = 16,
    parameter int         XW           = $clog2(WIDTH),
    parameter int         YW           = $clog2(HEIGHT),
    parameter int         PW           = $clog2(WIDTH*HEIGHT+1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [XW-1:0]    wr_x,
    input  logic [YW-1:0]    wr_y,
    input  logic             wr_val,
    input  logic [XW-1:0]    rd_x,
    input  logic [YW-1:0]    rd_y,
    output logic             rd_cell,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count,
    output logic [PW-1:0]    population
);

    typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

    state_t                               state;
    logic                                 sel;
    logic [1:0][HEIGHT-1:0][WIDTH-1:0]    planes;
    logic [XW-1:0]                        cx;
    logic [YW-1:0]                        cy;
    logic [PW-1:0]                        acc;

    logic [XW-1:0] nx [3];
    logic [YW-1:0] ny [3];
    logic          vx [3];
    logic          vy [3];
    logic [3:0]    ncnt;
    logic          alive;
    logic          nv;
    logic          rd_ok;
    logic          wr_ok;

    assign rd_ok = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
    assign wr_ok = (int'(wr_x) < WIDTH) && (int'(wr_y) < HEIGHT);

    // Neighbour window around the cursor; edge columns/rows either wrap or are masked off.
    always_comb begin
        nx[0] = (cx == '0) ? XW'(WIDTH-1) : cx - 1'b1;
        nx[1] = cx;
        nx[2] = (cx == XW'(WIDTH-1)) ? '0 : cx + 1'b1;
        ny[0] = (cy == '0) ? YW'(HEIGHT-1) : cy - 1'b1;
        ny[1] = cy;
        ny[2] = (cy == YW'(HEIGHT-1)) ? '0 : cy + 1'b1;
        vx[0] = WRAP || (cx != '0);
        vx[1] = 1'b1;
        vx[2] = WRAP || (cx != XW'(WIDTH-1));
        vy[0] = WRAP || (cy != '0);
        vy[1] = 1'b1;
        vy[2] = WRAP || (cy != YW'(HEIGHT-1));
        ncnt  = '0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(i == 1 && j == 1) && vx[i] && vy[j])
                    ncnt = ncnt + {3'b000, planes[sel][ny[j]][nx[i]]};
            end
        end
        alive = planes[sel][cy][cx];
        nv    = alive ? SURVIVE_MASK[ncnt] : BIRTH_MASK[ncnt];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= 1'b0;
            planes     <= '0;
            cx         <= '0;
            cy         <= '0;
            acc        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gen_count  <= '0;
            population <= '0;
            rd_cell    <= 1'b0;
        end else begin
            rd_cell <= rd_ok ? planes[sel][rd_y][rd_x] : 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    // clear wins over everything and drops a coincident start
                    if (clear) begin
                        planes[sel] <= '0;
                        population  <= '0;
                    end else begin
                        if (wr_en && wr_ok)
                            planes[sel][wr_y][wr_x] <= wr_val;
                        if (start) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            cx    <= '0;
                            cy    <= '0;
                            acc   <= '0;
                        end
                    end
                end
                RUN: begin
                    planes[~sel][cy][cx] <= nv;
                    acc <= acc + PW'(nv);
                    if (cx == XW'(WIDTH-1)) begin
                        cx <= '0;
                        if (cy == YW'(HEIGHT-1)) begin
                            state <= COMMIT;
                            done  <= 1'b1;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                COMMIT: begin
                    // swap lands at the end of this cycle so reads here still see the old plane
                    sel        <= ~sel;
                    gen_count  <= gen_count + 1'b1;
                    population <= acc;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Directed bench: three 8x6 engines (wrap/default, dead-edge/default, wrap/birth-only)
// share stimulus; each scenario checks grids read back through rd_cell.
module tb_life_engine;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int GW = 16;
    localparam int PW = 6;

    logic          clock = 1'b0;
    logic          reset, start, clear, wr_en, wr_val;
    logic [2:0]    wr_x, wr_y, rd_x, rd_y;
    logic [2:0]    rd_cell, busy, done;
    logic [GW-1:0] gen_c [3];
    logic [PW-1:0] pop   [3];

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    life_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1'b1)) u0 (
        .clock(clock), .reset(reset), .start(start), .clear(clear), .wr_en(wr_en),
        .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val), .rd_x(rd_x), .rd_y(rd_y),
        .rd_cell(rd_cell[0]), .busy(busy[0]), .done(done[0]),
        .gen_count(gen_c[0]), .population(pop[0]));

    life_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1'b0)) u1 (
        .clock(clock), .reset(reset), .start(start), .clear(clear), .wr_en(wr_en),
        .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val), .rd_x(rd_x), .rd_y(rd_y),
        .rd_cell(rd_cell[1]), .busy(busy[1]), .done(done[1]),
        .gen_count(gen_c[1]), .population(pop[1]));

    life_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1'b1),
                  .BIRTH_MASK(9'b000001000), .SURVIVE_MASK(9'b000000000)) u2 (
        .clock(clock), .reset(reset), .start(start), .clear(clear), .wr_en(wr_en),
        .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val), .rd_x(rd_x), .rd_y(rd_y),
        .rd_cell(rd_cell[2]), .busy(busy[2]), .done(done[2]),
        .gen_count(gen_c[2]), .population(pop[2]));

    function automatic logic [47:0] cells(input int x0, y0, x1, y1, x2, y2);
        logic [47:0] g;
        g = '0;
        g[y0*W+x0] = 1'b1;
        g[y1*W+x1] = 1'b1;
        g[y2*W+x2] = 1'b1;
        return g;
    endfunction

    logic [47:0] horiz, vert, pair;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_val = 1'b0;
        wr_x = '0; wr_y = '0; rd_x = '0; rd_y = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_cell(input int x, input int y, input logic v);
        wr_en = 1'b1; wr_x = 3'(x); wr_y = 3'(y); wr_val = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_grids(output logic [47:0] g0, output logic [47:0] g1, output logic [47:0] g2);
        g0 = '0; g1 = '0; g2 = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                rd_x = 3'(x); rd_y = 3'(y);
                tick();
                g0[y*W+x] = rd_cell[0];
                g1[y*W+x] = rd_cell[1];
                g2[y*W+x] = rd_cell[2];
            end
        end
    endtask

    // n = cycle index (start edge + n) where done is seen; bounded at 200.
    task automatic run_gen(output int n, output bit busy_ok);
        start = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        n = 1; busy_ok = 1'b1;
        while (!done[0] && n < 200) begin
            if (busy !== 3'b111) busy_ok = 1'b0;
            tick();
            n++;
        end
        if (busy !== 3'b111) busy_ok = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [47:0] g0, g1, g2;
        do_reset();
        tests++;
        if (busy !== 3'b000 || done !== 3'b000) begin
            fails++; $display("FAIL reset_ctrl busy=%b done=%b want 000/000", busy, done);
        end
        tests++;
        if (gen_c[0] !== 16'd0 || pop[0] !== 6'd0) begin
            fails++; $display("FAIL reset_counts gen=%0d pop=%0d want 0/0", gen_c[0], pop[0]);
        end
        read_grids(g0, g1, g2);
        tests++;
        if (g0 !== 48'd0 || g1 !== 48'd0 || g2 !== 48'd0) begin
            fails++; $display("FAIL reset_grid got %h %h %h want 0", g0, g1, g2);
        end
    endtask

    task automatic test_blinker();
        logic [47:0] g0, g1, g2;
        int n; bit bok;
        do_reset();
        write_cell(2, 3, 1'b1);
        write_cell(3, 3, 1'b1);
        write_cell(4, 3, 1'b1);
        write_cell(3, 7, 1'b1);
        write_cell(1, 6, 1'b1);
        read_grids(g0, g1, g2);
        tests++;
        if (g0 !== horiz || pop[0] !== 6'd0) begin
            fails++; $display("FAIL write_load grid=%h pop=%0d want %h/0", g0, pop[0], horiz);
        end
        rd_x = 3'd0; rd_y = 3'd6;
        tick();
        tests++;
        if (rd_cell !== 3'b000) begin
            fails++; $display("FAIL rd_out_of_range got %b want 000", rd_cell);
        end
        run_gen(n, bok);
        tests++;
        if (n !== 49 || !bok) begin
            fails++; $display("FAIL gen_latency done_at=%0d busy_ok=%0d want 49/1", n, bok);
        end
        tests++;
        if (busy !== 3'b000 || done !== 3'b000) begin
            fails++; $display("FAIL post_commit busy=%b done=%b want 000/000", busy, done);
        end
        read_grids(g0, g1, g2);
        tests++;
        if (g0 !== vert || g1 !== vert || g2 !== pair) begin
            fails++; $display("FAIL blinker_gen1 got %h %h %h want %h %h %h", g0, g1, g2, vert, vert, pair);
        end
        tests++;
        if (gen_c[0] !== 16'd1 || pop[0] !== 6'd3 || pop[2] !== 6'd2) begin
            fails++; $display("FAIL blinker_counts gen=%0d pop0=%0d pop2=%0d want 1/3/2", gen_c[0], pop[0], pop[2]);
        end
        run_gen(n, bok);
        read_grids(g0, g1, g2);
        tests++;
        if (g0 !== horiz || gen_c[0] !== 16'd2 || pop[0] !== 6'd3) begin
            fails++; $display("FAIL blinker_gen2 grid=%h gen=%0d pop=%0d want %h/2/3", g0, gen_c[0], pop[0], horiz);
        end
    endtask

    task automatic test_edges();
        logic [47:0] g0, g1, g2;
        int n; bit bok;
        do_reset();
        write_cell(7, 2, 1'b1);
        write_cell(0, 2, 1'b1);
        write_cell(1, 2, 1'b1);
        run_gen(n, bok);
        read_grids(g0, g1, g2);
        tests++;
        if (g0 !== cells(0, 1, 0, 2, 0, 3) || pop[0] !== 6'd3) begin
            fails++; $display("FAIL wrap_edge grid=%h pop=%0d want %h/3", g0, pop[0], cells(0, 1, 0, 2, 0, 3));
        end
        tests++;
        if (g1 !== 48'd0 || pop[1] !== 6'd0) begin
            fails++; $display("FAIL dead_edge grid=%h pop=%0d want 0/0", g1, pop[1]);
        end
        tests++;
        if (g2 !== cells(0, 1, 0, 3, 0, 3) || pop[2] !== 6'd2) begin
            fails++; $display("FAIL birth_only_edge grid=%h pop=%0d want %h/2", g2, pop[2], cells(0, 1, 0, 3, 0, 3));
        end
    endtask

    task automatic test_clear_start();
        logic [47:0] g0, g1, g2;
        int n; bit bok;
        do_reset();
        write_cell(2, 3, 1'b1);
        write_cell(3, 3, 1'b1);
        write_cell(4, 3, 1'b1);
        run_gen(n, bok);
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        tests++;
        if (busy !== 3'b000) begin
            fails++; $display("FAIL clear_start_busy got %b want 000", busy);
        end
        tick();
        tests++;
        if (busy !== 3'b000 || gen_c[0] !== 16'd1 || pop[0] !== 6'd0) begin
            fails++; $display("FAIL clear_counts busy=%b gen=%0d pop=%0d want 000/1/0", busy, gen_c[0], pop[0]);
        end
        read_grids(g0, g1, g2);
        tests++;
        if (g0 !== 48'd0 || g1 !== 48'd0) begin
            fails++; $display("FAIL clear_grid got %h %h want 0", g0, g1);
        end
    endtask

    task automatic test_write_with_start();
        logic [47:0] g0, g1, g2;
        int n; bit bok;
        do_reset();
        write_cell(2, 3, 1'b1);
        write_cell(3, 3, 1'b1);
        wr_en = 1'b1; wr_x = 3'd4; wr_y = 3'd3; wr_val = 1'b1;
        run_gen(n, bok);
        read_grids(g0, g1, g2);
        tests++;
        if (g0 !== vert || n !== 49) begin
            fails++; $display("FAIL wr_plus_start grid=%h done_at=%0d want %h/49", g0, n, vert);
        end
    endtask

    task automatic test_run_collisions();
        logic [47:0] g0, g1, g2;
        int n; bit bok;
        int dc;
        do_reset();
        write_cell(2, 3, 1'b1);
        write_cell(3, 3, 1'b1);
        write_cell(4, 3, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        dc = 0;
        wr_x = 3'd0; wr_y = 3'd0; wr_val = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            if (done[0]) dc++;
            wr_en = (c == 6);
            start = (c == 12);
            tick();
        end
        wr_en = 1'b0; start = 1'b0;
        tests++;
        if (dc !== 1 || busy !== 3'b000) begin
            fails++; $display("FAIL start_in_run done_pulses=%0d busy=%b want 1/000", dc, busy);
        end
        read_grids(g0, g1, g2);
        tests++;
        if (g0 !== vert || gen_c[0] !== 16'd1) begin
            fails++; $display("FAIL wr_in_run grid=%h gen=%0d want %h/1", g0, gen_c[0], vert);
        end
        run_gen(n, bok);
        read_grids(g0, g1, g2);
        tests++;
        if (g0 !== horiz) begin
            fails++; $display("FAIL wr_in_run_next grid=%h want %h", g0, horiz);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [47:0] g0, g1, g2;
        int n; bit bok;
        do_reset();
        write_cell(2, 3, 1'b1);
        write_cell(3, 3, 1'b1);
        write_cell(4, 3, 1'b1);
        run_gen(n, bok);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (busy !== 3'b000 || done !== 3'b000 || gen_c[0] !== 16'd0 || pop[0] !== 6'd0) begin
            fails++; $display("FAIL reset_mid_run busy=%b done=%b gen=%0d pop=%0d want 000/000/0/0",
                              busy, done, gen_c[0], pop[0]);
        end
        read_grids(g0, g1, g2);
        tests++;
        if (g0 !== 48'd0 || g1 !== 48'd0 || g2 !== 48'd0) begin
            fails++; $display("FAIL reset_mid_grid got %h %h %h want 0", g0, g1, g2);
        end
        run_gen(n, bok);
        tests++;
        if (n !== 49 || !bok || gen_c[0] !== 16'd1) begin
            fails++; $display("FAIL rerun_after_reset done_at=%0d busy_ok=%0d gen=%0d want 49/1/1", n, bok, gen_c[0]);
        end
    endtask

    initial begin
        horiz = cells(2, 3, 3, 3, 4, 3);
        vert  = cells(3, 2, 3, 3, 3, 4);
        pair  = cells(3, 2, 3, 4, 3, 4);
        test_reset();
        test_blinker();
        test_edges();
        test_clear_start();
        test_write_with_start();
        test_run_collisions();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
